job_completion_arbiter: RTL and testbench

Per-kernel completion tracker and ordered completion arbiter for the database action framework. It sits between the job scheduler's kernel-start outputs, the kernels' `engine_done` lines, and the completion engine. It captures each dispatched job's PID/job-ID, detects done edges, and round-robin arbitrates simultaneous completions into a FIFO. It drains that FIFO only while the completion engine asserts ready, so no completion is dropped under back-pressure.

---
 rtl/job_completion_arbiter_if.sv | 46 ++++
 rtl/job_completion_arbiter.sv | 159 +++++++++++++++
 tb/tb_job_completion_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/job_completion_arbiter_if.sv
// Completion arbiter handshake bundle.
// Scheduler/engine side is master, arbiter is slave.
interface job_completion_arbiter_if #(
  parameter int KERNEL_NUM = 8,
  parameter int INFO_W     = 41,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [KERNEL_NUM-1:0] engine_start;
  logic [INFO_W-1:0]     kernel_info_i;
  logic [KERNEL_NUM-1:0] engine_done;
  logic [KERNEL_NUM-1:0] busy_o;
  logic [KERNEL_NUM-1:0] kernel_release_o;
  logic                  complete_ready_i;
  logic                  complete_push_o;
  logic [INFO_W-1:0]     return_data_o;
  logic [CW-1:0]         fifo_count_o;
  logic                  err_o;

  modport master (
    output engine_start,
    output kernel_info_i,
    output engine_done,
    output complete_ready_i,
    input  busy_o,
    input  kernel_release_o,
    input  complete_push_o,
    input  return_data_o,
    input  fifo_count_o,
    input  err_o
  );

  modport slave (
    input  engine_start,
    input  kernel_info_i,
    input  engine_done,
    input  complete_ready_i,
    output busy_o,
    output kernel_release_o,
    output complete_push_o,
    output return_data_o,
    output fifo_count_o,
    output err_o
  );
endinterface

// File: rtl/job_completion_arbiter.sv
// Per-kernel job tracker with round-robin
// completion arbitration into an ordered FIFO.
module job_completion_arbiter #(
  parameter int KERNEL_NUM = 8,
  parameter int INFO_W     = 41,
  parameter int FIFO_DEPTH = 16
) (
  input logic clk,
  input logic rst,
  job_completion_arbiter_if.slave bus
);
  localparam int PW =
    (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
  localparam int AW =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    PEND = 2'd2
  } kst_t;

  kst_t              st_q [KERNEL_NUM];
  kst_t              st_d [KERNEL_NUM];
  logic [INFO_W-1:0] info_q [KERNEL_NUM];
  logic [INFO_W-1:0] mem [FIFO_DEPTH];

  logic [KERNEL_NUM-1:0] done_prev_q;
  logic [KERNEL_NUM-1:0] done_edge;
  logic [KERNEL_NUM-1:0] idle;
  logic [KERNEL_NUM-1:0] pend;
  logic [KERNEL_NUM-1:0] gnt;
  logic [KERNEL_NUM-1:0] rel_q;
  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         gnt_idx;
  logic                  gnt_vld;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  err_q;
  logic                  pop;
  logic                  has_room;

  assign done_edge = bus.engine_done & ~done_prev_q;
  assign has_room  = count_q < CW'(FIFO_DEPTH);
  assign pop       = bus.complete_ready_i
                   & (count_q != '0);

  // Kernel state register
  always_ff @(posedge clk) begin
    for (int k = 0; k < KERNEL_NUM; k++) begin
      if (rst) st_q[k] <= IDLE;
      else     st_q[k] <= st_d[k];
    end
  end

  // Kernel next state: start in IDLE beats a done edge
  always_comb begin
    for (int k = 0; k < KERNEL_NUM; k++) begin
      st_d[k] = st_q[k];
      unique case (st_q[k])
        IDLE: if (bus.engine_start[k]) st_d[k] = BUSY;
        BUSY: if (done_edge[k])        st_d[k] = PEND;
        PEND: if (gnt[k])              st_d[k] = IDLE;
        default:                       st_d[k] = IDLE;
      endcase
    end
  end

  // Kernel state decode
  always_comb begin
    idle = '0;
    pend = '0;
    for (int k = 0; k < KERNEL_NUM; k++) begin
      idle[k] = (st_q[k] == IDLE);
      pend[k] = (st_q[k] == PEND);
    end
  end

  // Round-robin pick of the first PEND kernel from ptr
  always_comb begin
    int s;
    logic [PW-1:0] idx;
    s       = 0;
    idx     = '0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < KERNEL_NUM; i++) begin
      s = int'(ptr_q) + i;
      if (s >= KERNEL_NUM) s = s - KERNEL_NUM;
      idx = PW'(s);
      if (!gnt_vld && has_room && pend[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  // Job info capture on an accepted start
  always_ff @(posedge clk) begin
    for (int k = 0; k < KERNEL_NUM; k++) begin
      if (rst)
        info_q[k] <= '0;
      else if (bus.engine_start[k] && idle[k])
        info_q[k] <= bus.kernel_info_i;
    end
  end

  // Edge history, rr pointer, release pulse, error
  always_ff @(posedge clk) begin
    if (rst) begin
      done_prev_q <= '1;
      ptr_q       <= '0;
      rel_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      done_prev_q <= bus.engine_done;
      rel_q       <= gnt;
      if (|(bus.engine_start & ~idle))
        err_q <= 1'b1;
      if (gnt_vld)
        ptr_q <= (gnt_idx == PW'(KERNEL_NUM - 1))
               ? '0 : gnt_idx + PW'(1);
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (gnt_vld) mem[wr_ptr_q] <= info_q[gnt_idx];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (gnt_vld) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({gnt_vld, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.busy_o           = ~idle;
  assign bus.kernel_release_o = rel_q;
  assign bus.complete_push_o  = pop;
  assign bus.return_data_o    = pop ? mem[rd_ptr_q]
                                    : '0;
  assign bus.fifo_count_o     = count_q;
  assign bus.err_o            = err_q;
endmodule

// File: tb/tb_job_completion_arbiter.sv
// Bench for job_completion_arbiter: vector table,
// directed corner sequences and random vs. model.
module tb_job_completion_arbiter;
  localparam int K  = 8;
  localparam int W  = 41;
  localparam int D  = 4;

  typedef struct {
    logic         rst;
    logic [K-1:0] start;
    logic [W-1:0] info;
    logic [K-1:0] done;
    logic         ready;
    logic [K-1:0] e_busy;
    logic [K-1:0] e_rel;
    logic         e_push;
    logic [W-1:0] e_data;
    int           e_cnt;
    logic         e_err;
  } vec_t;

  logic clk;
  logic rst;

  job_completion_arbiter_if #(
    .KERNEL_NUM(K), .INFO_W(W), .FIFO_DEPTH(D)
  ) bus ();

  job_completion_arbiter #(
    .KERNEL_NUM(K), .INFO_W(W), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: 0 idle, 1 busy, 2 pending
  int           m_st [K];
  logic [W-1:0] m_info [K];
  logic [K-1:0] m_prev;
  logic [K-1:0] m_rel;
  int           m_ptr;
  logic [W-1:0] m_q [$];
  bit           m_err;
  bit           m_valid = 1'b0;

  logic [W-1:0] push_log [$];
  logic [K-1:0] cur_done;
  logic         cur_ready;
  vec_t         tv [14];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rs, input logic [K-1:0] s,
    input logic [W-1:0] inf, input logic [K-1:0] dn,
    input logic rd, input logic [K-1:0] eb,
    input logic [K-1:0] er, input logic ep,
    input logic [W-1:0] ed, input int ec,
    input logic ee);
    vec_t v;
    v.rst = rs; v.start = s; v.info = inf;
    v.done = dn; v.ready = rd;
    v.e_busy = eb; v.e_rel = er; v.e_push = ep;
    v.e_data = ed; v.e_cnt = ec; v.e_err = ee;
    return v;
  endfunction

  task automatic model_check(input vec_t v);
    logic [K-1:0] eb;
    bit ep;
    logic [W-1:0] ed;
    eb = '0;
    for (int k = 0; k < K; k++) eb[k] = (m_st[k] != 0);
    ep = v.ready && (m_q.size() != 0);
    ed = ep ? m_q[0] : '0;
    chk("busy", 64'(bus.busy_o), 64'(eb));
    chk("release", 64'(bus.kernel_release_o),
        64'(m_rel));
    chk("push", 64'(bus.complete_push_o), 64'(ep));
    chk("data", 64'(bus.return_data_o), 64'(ed));
    chk("count", 64'(bus.fifo_count_o),
        64'(m_q.size()));
    chk("err", 64'(bus.err_o), 64'(m_err));
  endtask

  task automatic model_step(input vec_t v);
    int g;
    bit pop;
    bit e;
    logic [W-1:0] gi;
    if (v.rst) begin
      for (int k = 0; k < K; k++) begin
        m_st[k] = 0;
        m_info[k] = '0;
      end
      m_prev = '1; m_ptr = 0; m_rel = '0;
      m_err = 1'b0; m_q.delete(); m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    pop = v.ready && (m_q.size() != 0);
    g = -1;
    gi = '0;
    if (m_q.size() < D)
      for (int i = 0; i < K; i++) begin
        int k;
        k = (m_ptr + i) % K;
        if (g < 0 && m_st[k] == 2) g = k;
      end
    if (g >= 0) gi = m_info[g];
    for (int k = 0; k < K; k++) begin
      e = v.done[k] && !m_prev[k];
      if (m_st[k] == 0) begin
        if (v.start[k]) begin
          m_st[k] = 1;
          m_info[k] = v.info;
        end
      end else begin
        if (v.start[k]) m_err = 1'b1;
        if (m_st[k] == 1 && e) m_st[k] = 2;
        else if (m_st[k] == 2 && k == g) m_st[k] = 0;
      end
    end
    m_rel = '0;
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_rel[g] = 1'b1;
      m_q.push_back(gi);
      m_ptr = (g + 1) % K;
    end
    m_prev = v.done;
  endtask

  task automatic cycle(input vec_t v, input bit use_exp);
    rst = v.rst;
    bus.engine_start = v.start;
    bus.kernel_info_i = v.info;
    bus.engine_done = v.done;
    bus.complete_ready_i = v.ready;
    @(negedge clk);
    if (bus.complete_push_o === 1'b1)
      push_log.push_back(bus.return_data_o);
    if (use_exp) begin
      chk("tv_busy", 64'(bus.busy_o), 64'(v.e_busy));
      chk("tv_release", 64'(bus.kernel_release_o),
          64'(v.e_rel));
      chk("tv_push", 64'(bus.complete_push_o),
          64'(v.e_push));
      chk("tv_data", 64'(bus.return_data_o),
          64'(v.e_data));
      chk("tv_count", 64'(bus.fifo_count_o),
          64'(v.e_cnt));
      chk("tv_err", 64'(bus.err_o), 64'(v.e_err));
    end
    if (m_valid) model_check(v);
    model_step(v);
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [K-1:0] s = '0,
                      input logic [W-1:0] inf = '0);
    cycle(mk(1'b0, s, inf, cur_done, cur_ready,
             '0, '0, 1'b0, '0, 0, 1'b0), 1'b0);
  endtask

  task automatic do_reset(input int n = 2);
    repeat (n)
      cycle(mk(1'b1, '0, '0, cur_done, cur_ready,
               '0, '0, 1'b0, '0, 0, 1'b0), 1'b0);
  endtask

  task automatic chk_log(input string nm,
                         input logic [W-1:0] exp [$]);
    logic [63:0] a;
    chk({nm, "_n"}, 64'(push_log.size()),
        64'(exp.size()));
    foreach (exp[i]) begin
      a = (i < push_log.size()) ? 64'(push_log[i])
                                : 64'hFFFF_FFFF_FFFF_FFFF;
      chk(nm, a, 64'(exp[i]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ex [$];
    logic [63:0] r;

    // kernel 3 single job, exact cycle timing
    tv[0] = mk(0, 8'h08, 41'h1_0000_00AA, 8'hFF, 1,
               8'h00, 8'h00, 0, '0, 0, 0);
    for (int i = 1; i < 10; i++)
      tv[i] = mk(0, 8'h00, '0, 8'hF7, 1,
                 8'h08, 8'h00, 0, '0, 0, 0);
    tv[10] = mk(0, 8'h00, '0, 8'hFF, 1,
                8'h08, 8'h00, 0, '0, 0, 0);
    tv[11] = mk(0, 8'h00, '0, 8'hFF, 1,
                8'h08, 8'h00, 0, '0, 0, 0);
    tv[12] = mk(0, 8'h00, '0, 8'hFF, 1,
                8'h00, 8'h08, 1, 41'h1_0000_00AA, 1, 0);
    tv[13] = mk(0, 8'h00, '0, 8'hFF, 1,
                8'h00, 8'h00, 0, '0, 0, 0);

    cur_done = 8'hFF;
    cur_ready = 1'b1;
    do_reset();
    chk("reset_busy", 64'(bus.busy_o), 64'd0);
    chk("reset_count", 64'(bus.fifo_count_o), 64'd0);
    foreach (tv[i]) cycle(tv[i], 1'b1);

    // all eight complete together, pointer from 0
    do_reset();
    cur_done = '0;
    tick();
    for (int k = 0; k < K; k++)
      tick(K'(1) << k, W'(k));
    tick();
    push_log.delete();
    cur_done = '1;
    repeat (14) tick();
    ex.delete();
    for (int k = 0; k < K; k++) ex.push_back(W'(k));
    chk_log("all8_order", ex);
    cur_done = '0;
    tick(8'h20, 41'h55);
    tick(8'h04, 41'h22);
    tick();
    push_log.delete();
    cur_done = 8'h24;
    repeat (6) tick();
    ex.delete();
    ex.push_back(41'h22);
    ex.push_back(41'h55);
    chk_log("ptr_wrap_order", ex);

    // back-pressure with a full FIFO
    do_reset();
    cur_done = '0;
    cur_ready = 1'b0;
    tick();
    for (int k = 0; k < 6; k++)
      tick(K'(1) << k, W'(12'h100 + k));
    push_log.delete();
    cur_done = 8'h3F;
    repeat (10) tick();
    chk("bp_count", 64'(bus.fifo_count_o), 64'd4);
    chk("bp_busy", 64'(bus.busy_o), 64'h30);
    chk("bp_nopush", 64'(push_log.size()), 64'd0);
    cur_ready = 1'b1;
    repeat (12) tick();
    ex.delete();
    for (int k = 0; k < 6; k++)
      ex.push_back(W'(12'h100 + k));
    chk_log("bp_order", ex);
    chk("bp_drained", 64'(bus.fifo_count_o), 64'd0);
    chk("bp_idle", 64'(bus.busy_o), 64'd0);

    // restart of a busy kernel is an error
    do_reset();
    cur_done = '0;
    tick();
    tick(8'h04, 41'h2_0000_0022);
    tick(8'h04, 41'h0_DEAD_BEEF);
    chk("err_set", 64'(bus.err_o), 64'd1);
    push_log.delete();
    cur_done = 8'h04;
    repeat (5) tick();
    ex.delete();
    ex.push_back(41'h2_0000_0022);
    chk_log("err_info_kept", ex);
    chk("err_sticky", 64'(bus.err_o), 64'd1);

    // reset with a pending kernel and queued entries
    do_reset();
    chk("err_cleared", 64'(bus.err_o), 64'd0);
    cur_done = '0;
    cur_ready = 1'b0;
    tick();
    tick(8'h01, 41'hA0);
    tick(8'h02, 41'hA1);
    tick(8'h04, 41'hA2);
    tick(8'h20, 41'hA5);
    cur_done = 8'h07;
    repeat (5) tick();
    chk("mid_count", 64'(bus.fifo_count_o), 64'd3);
    cur_done = 8'h27;
    tick();
    do_reset(1);
    chk("mid_busy", 64'(bus.busy_o), 64'd0);
    chk("mid_cnt0", 64'(bus.fifo_count_o), 64'd0);
    chk("mid_rel", 64'(bus.kernel_release_o), 64'd0);
    cur_ready = 1'b1;
    push_log.delete();
    repeat (6) tick();
    chk("mid_nopush", 64'(push_log.size()), 64'd0);

    // done held high across two jobs on kernel 1
    do_reset();
    cur_done = '0;
    tick();
    push_log.delete();
    tick(8'h02, 41'hB1);
    cur_done = 8'h02;
    repeat (5) tick();
    tick(8'h02, 41'hB2);
    repeat (6) tick();
    chk("held_busy", 64'(bus.busy_o), 64'h02);
    chk("held_one", 64'(push_log.size()), 64'd1);
    cur_done = '0;
    tick();
    cur_done = 8'h02;
    repeat (5) tick();
    ex.delete();
    ex.push_back(41'hB1);
    ex.push_back(41'hB2);
    chk_log("held_order", ex);

    // random traffic against the model
    do_reset();
    cur_done = '0;
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      logic [K-1:0] s;
      r = {$urandom(), $urandom()};
      s = ($urandom_range(3) == 0)
        ? (K'(1) << $urandom_range(K - 1)) : '0;
      if ($urandom_range(2) == 0)
        cur_done = cur_done
                 ^ (K'(1) << $urandom_range(K - 1));
      cur_ready = ((i % 200) < 50) ? 1'b0
                : ($urandom_range(3) != 0);
      v = mk(($urandom_range(499) == 0), s, r[W-1:0],
             cur_done, cur_ready,
             '0, '0, 1'b0, '0, 0, 1'b0);
      cycle(v, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
